// File: rtl/mac_result_collector_pkg.sv
// Shared types and defaults for the MAC result collector.
// States and the sum width are common with the MAC engine side.
package mac_collector_pkg;

    localparam int unsigned MAC_SUM_W = 20;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_DRAIN   = 2'd2
    } state_e;

endpackage

// File: rtl/mac_result_collector_if.sv
// Engine-side result handshake plus downstream valid/ready stream.
// The collector uses the slave modport; the engine/sink side uses master.
interface mac_result_collector_if
    import mac_collector_pkg::*;
#(
    parameter int unsigned SUM_W = MAC_SUM_W
);
    logic             mac_valid;
    logic [SUM_W-1:0] mac_sum;
    logic             mac_ready;
    logic             out_valid;
    logic [SUM_W-1:0] out_data;
    logic             out_ready;

    modport master (
        output mac_valid, mac_sum, out_ready,
        input  mac_ready, out_valid, out_data
    );

    modport slave (
        input  mac_valid, mac_sum, out_ready,
        output mac_ready, out_valid, out_data
    );
endinterface

// File: rtl/mac_result_collector_fifo.sv
// First-word-fall-through FIFO with registered full flag and synchronous clear.
// The head reads as zero while empty so the output is defined out of reset.
module result_fifo
    import mac_collector_pkg::*;
#(
    parameter int unsigned WIDTH = MAC_SUM_W,
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   nrst,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   clear,
    input  logic [WIDTH-1:0]       wdata,
    output logic [WIDTH-1:0]       rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full_q;
    logic             do_push, do_pop;

    assign do_push = push && !full_q;
    assign do_pop  = pop && (count_q != '0);

    always_comb begin
        count_d = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (do_pop && !do_push) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
        end else if (clear) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
        end else begin
            // Pointers wrap naturally since DEPTH is a power of two.
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_d;
            full_q  <= (count_d == CNT_W'(DEPTH));
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !clear) begin
            mem[wr_ptr_q] <= wdata;
        end
    end

    assign empty = (count_q == '0);
    assign full  = full_q;
    assign count = count_q;
    assign rdata = empty ? '0 : mem[rd_ptr_q];

endmodule

// File: rtl/mac_result_collector.sv
// Collects a programmed batch of MAC sums into a FWFT FIFO and pulses done once drained.
// Optional COLLECTOR_CNT_EN adds a saturating lifetime accept counter (result_count).
module mac_result_collector
    import mac_collector_pkg::*;
#(
    parameter int unsigned SUM_W = MAC_SUM_W,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 8
) (
    input  logic                   clk,
    input  logic                   nrst,
    input  logic                   start,
    input  logic [CNT_W-1:0]       num_results,
    input  logic                   flush,
    mac_result_collector_if.slave  bus,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic                   busy,
    output logic                   done
`ifdef COLLECTOR_CNT_EN
    ,
    output logic [15:0]            result_count
`endif
);
    state_e           state_q, state_d;
    logic [CNT_W-1:0] remaining_q, remaining_d;
    logic             done_q, done_d;
    logic             fifo_full, fifo_empty;
    logic             accept, pop;

    // Ready comes only from state and the registered full flag.
    assign bus.mac_ready = (state_q == S_COLLECT) && !fifo_full;
    assign accept        = bus.mac_valid && bus.mac_ready && !flush;
    assign pop           = bus.out_valid && bus.out_ready;

    result_fifo #(
        .WIDTH (SUM_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .nrst  (nrst),
        .push  (accept),
        .pop   (pop),
        .clear (flush),
        .wdata (bus.mac_sum),
        .rdata (bus.out_data),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign bus.out_valid = !fifo_empty;

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        done_d      = 1'b0;
        if (flush) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        if (num_results != '0) begin
                            state_d     = S_COLLECT;
                            remaining_d = num_results;
                        end else begin
                            done_d = 1'b1;
                        end
                    end
                end
                S_COLLECT: begin
                    if (accept) begin
                        remaining_d = remaining_q - CNT_W'(1);
                        if (remaining_q == CNT_W'(1)) state_d = S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (fifo_empty) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q     <= S_IDLE;
            remaining_q <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            done_q      <= done_d;
        end
    end

    assign busy = (state_q != S_IDLE);
    assign done = done_q;

`ifdef COLLECTOR_CNT_EN
    logic [15:0] result_count_q;

    // Survives flush; only reset clears it.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            result_count_q <= '0;
        end else if (accept && (result_count_q != 16'hFFFF)) begin
            result_count_q <= result_count_q + 16'd1;
        end
    end

    assign result_count = result_count_q;
`endif

endmodule

// File: tb/tb_mac_result_collector.sv
// Self-checking bench for mac_result_collector: directed scenarios plus randomized batches
// scored against the sequence of sums the bench itself handed to the engine handshake.
module tb_mac_result_collector;
    import mac_collector_pkg::*;

    localparam int unsigned SUM_W = 20;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned CNT_W = 8;

    logic             clk = 1'b0;
    logic             nrst = 1'b0;
    logic             start = 1'b0;
    logic             flush = 1'b0;
    logic [CNT_W-1:0] num_results = '0;
    logic [2:0]       fifo_count;
    logic             busy, done;
`ifdef COLLECTOR_CNT_EN
    logic [15:0]      result_count;
`endif

    mac_result_collector_if #(.SUM_W(SUM_W)) bus ();

    logic rand_ready = 1'b0;
    logic ready_force = 1'b0;
    logic rnd_bit = 1'b0;
    assign bus.out_ready = rand_ready ? rnd_bit : ready_force;

    int vectors = 0;
    int miscompares = 0;
    int sent_total = 0;
    logic [SUM_W-1:0] sent_q [$];
    logic [SUM_W-1:0] got_q [$];

    always #5 clk = ~clk;

    mac_result_collector #(
        .SUM_W (SUM_W),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk          (clk),
        .nrst         (nrst),
        .start        (start),
        .num_results  (num_results),
        .flush        (flush),
        .bus          (bus),
        .fifo_count   (fifo_count),
        .busy         (busy),
        .done         (done)
`ifdef COLLECTOR_CNT_EN
        ,
        .result_count (result_count)
`endif
    );

    always @(posedge clk) begin
        #1;
        rnd_bit = 1'($urandom_range(0, 1));
    end

    // Records every item the sink actually takes.
    always @(negedge clk) begin
        if (nrst && !flush && bus.out_valid && bus.out_ready) got_q.push_back(bus.out_data);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_batch(input int n);
        start = 1'b1;
        num_results = CNT_W'(n);
        tick();
        start = 1'b0;
    endtask

    task automatic engine_send(input logic [SUM_W-1:0] v, input int gap);
        int n = 0;
        bus.mac_valid = 1'b1;
        bus.mac_sum = v;
        while (!bus.mac_ready && n < 500) begin
            tick();
            n++;
        end
        vectors++;
        if (!bus.mac_ready) begin
            miscompares++;
            $display("FAIL engine_send: mac_ready still %b after %0d cycles, required 1", bus.mac_ready, n);
            bus.mac_valid = 1'b0;
            return;
        end
        tick();
        sent_q.push_back(v);
        sent_total++;
        bus.mac_valid = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (!done && n < 300) begin
            tick();
            n++;
        end
        vectors++;
        if (!done) begin
            miscompares++;
            $display("FAIL %s done: got 0 after %0d cycles, required 1", tag, n);
        end
    endtask

    task automatic test_reset();
        #12;
        vectors += 6;
        if (bus.mac_ready !== 1'b0) begin miscompares++; $display("FAIL reset mac_ready: got %b, required 0", bus.mac_ready); end
        if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL reset out_valid: got %b, required 0", bus.out_valid); end
        if (bus.out_data !== '0) begin miscompares++; $display("FAIL reset out_data: got %h, required 0", bus.out_data); end
        if (fifo_count !== '0) begin miscompares++; $display("FAIL reset fifo_count: got %0d, required 0", fifo_count); end
        if (busy !== 1'b0) begin miscompares++; $display("FAIL reset busy: got %b, required 0", busy); end
        if (done !== 1'b0) begin miscompares++; $display("FAIL reset done: got %b, required 0", done); end
`ifdef COLLECTOR_CNT_EN
        vectors++;
        if (result_count !== 16'd0) begin miscompares++; $display("FAIL reset result_count: got %0d, required 0", result_count); end
`endif
        @(posedge clk);
        #1;
        nrst = 1'b1;
        tick();
    endtask

    task automatic test_single();
        int base = got_q.size();
        sent_q.delete();
        ready_force = 1'b1;
        start_batch(1);
        vectors += 2;
        if (busy !== 1'b1) begin miscompares++; $display("FAIL single busy: got %b, required 1", busy); end
        if (bus.mac_ready !== 1'b1) begin miscompares++; $display("FAIL single mac_ready: got %b, required 1", bus.mac_ready); end
        engine_send(20'h00ABC, 0);
        vectors += 3;
        if (bus.out_valid !== 1'b1) begin miscompares++; $display("FAIL single out_valid: got %b, required 1", bus.out_valid); end
        if (bus.out_data !== 20'h00ABC) begin miscompares++; $display("FAIL single out_data: got %h, required 00abc", bus.out_data); end
        if (bus.mac_ready !== 1'b0) begin miscompares++; $display("FAIL single drain mac_ready: got %b, required 0", bus.mac_ready); end
        tick();
        vectors += 2;
        if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL single after pop out_valid: got %b, required 0", bus.out_valid); end
        if (done !== 1'b0) begin miscompares++; $display("FAIL single early done: got %b, required 0", done); end
        tick();
        vectors += 2;
        if (done !== 1'b1) begin miscompares++; $display("FAIL single done: got %b, required 1", done); end
        if (busy !== 1'b0) begin miscompares++; $display("FAIL single busy fall: got %b, required 0", busy); end
        tick();
        vectors += 2;
        if (done !== 1'b0) begin miscompares++; $display("FAIL single done width: got %b, required 0", done); end
        if (got_q.size() != base + 1 || got_q[base] !== 20'h00ABC) begin
            miscompares++;
            $display("FAIL single stream: got %0d items, required 1 item 00abc", got_q.size() - base);
        end
    endtask

    task automatic test_zero_batch();
        start_batch(0);
        vectors += 3;
        if (done !== 1'b1) begin miscompares++; $display("FAIL zero done: got %b, required 1", done); end
        if (busy !== 1'b0) begin miscompares++; $display("FAIL zero busy: got %b, required 0", busy); end
        if (bus.mac_ready !== 1'b0) begin miscompares++; $display("FAIL zero mac_ready: got %b, required 0", bus.mac_ready); end
        tick();
        vectors += 2;
        if (done !== 1'b0) begin miscompares++; $display("FAIL zero done width: got %b, required 0", done); end
        if (busy !== 1'b0) begin miscompares++; $display("FAIL zero busy later: got %b, required 0", busy); end
    endtask

    task automatic test_backpressure();
        int base = got_q.size();
        sent_q.delete();
        ready_force = 1'b0;
        start_batch(6);
        for (int i = 0; i < 4; i++) engine_send(SUM_W'($urandom), (i == 3) ? 0 : 1);
        vectors += 2;
        if (bus.mac_ready !== 1'b0) begin miscompares++; $display("FAIL backpressure mac_ready: got %b, required 0", bus.mac_ready); end
        if (fifo_count !== 3'd4) begin miscompares++; $display("FAIL backpressure count: got %0d, required 4", fifo_count); end
        bus.mac_valid = 1'b1;
        bus.mac_sum = SUM_W'($urandom);
        repeat (3) tick();
        vectors++;
        if (fifo_count !== 3'd4) begin miscompares++; $display("FAIL backpressure overfill: got %0d, required 4", fifo_count); end
        ready_force = 1'b1;
        engine_send(bus.mac_sum, 1);
        engine_send(SUM_W'($urandom), 1);
        wait_done("backpressure");
        vectors += 2;
        if (busy !== 1'b0) begin miscompares++; $display("FAIL backpressure busy: got %b, required 0", busy); end
        if (got_q.size() - base != 6) begin miscompares++; $display("FAIL backpressure items: got %0d, required 6", got_q.size() - base); end
        for (int i = 0; i < sent_q.size() && base + i < got_q.size(); i++) begin
            vectors++;
            if (got_q[base+i] !== sent_q[i]) begin miscompares++; $display("FAIL backpressure item %0d: got %h, required %h", i, got_q[base+i], sent_q[i]); end
        end
        tick();
    endtask

    task automatic test_same_cycle();
        int base = got_q.size();
        sent_q.delete();
        ready_force = 1'b0;
        start_batch(4);
        engine_send(SUM_W'($urandom), 1);
        engine_send(SUM_W'($urandom), 1);
        vectors += 2;
        if (fifo_count !== 3'd2) begin miscompares++; $display("FAIL same_cycle pre count: got %0d, required 2", fifo_count); end
        if (bus.mac_ready !== 1'b1) begin miscompares++; $display("FAIL same_cycle mac_ready: got %b, required 1", bus.mac_ready); end
        bus.mac_valid = 1'b1;
        bus.mac_sum = SUM_W'($urandom);
        ready_force = 1'b1;
        tick();
        sent_q.push_back(bus.mac_sum);
        sent_total++;
        bus.mac_valid = 1'b0;
        ready_force = 1'b0;
        vectors++;
        if (fifo_count !== 3'd2) begin miscompares++; $display("FAIL same_cycle count: got %0d, required 2", fifo_count); end
        ready_force = 1'b1;
        engine_send(SUM_W'($urandom), 1);
        wait_done("same_cycle");
        vectors++;
        if (got_q.size() - base != 4) begin miscompares++; $display("FAIL same_cycle items: got %0d, required 4", got_q.size() - base); end
        for (int i = 0; i < sent_q.size() && base + i < got_q.size(); i++) begin
            vectors++;
            if (got_q[base+i] !== sent_q[i]) begin miscompares++; $display("FAIL same_cycle item %0d: got %h, required %h", i, got_q[base+i], sent_q[i]); end
        end
        tick();
    endtask

    task automatic test_wrap_random();
        rand_ready = 1'b1;
        for (int b = 0; b < 4; b++) begin
            int n = (b == 0) ? 10 : int'($urandom_range(1, 12));
            int base = got_q.size();
            sent_q.delete();
            start_batch(n);
            for (int i = 0; i < n; i++) engine_send(SUM_W'($urandom), int'($urandom_range(0, 1)));
            wait_done("wrap_random");
            vectors++;
            if (got_q.size() - base != n) begin miscompares++; $display("FAIL wrap_random batch %0d items: got %0d, required %0d", b, got_q.size() - base, n); end
            for (int i = 0; i < sent_q.size() && base + i < got_q.size(); i++) begin
                vectors++;
                if (got_q[base+i] !== sent_q[i]) begin miscompares++; $display("FAIL wrap_random batch %0d item %0d: got %h, required %h", b, i, got_q[base+i], sent_q[i]); end
            end
        end
        rand_ready = 1'b0;
        tick();
    endtask

    task automatic test_flush();
        int base = got_q.size();
        ready_force = 1'b0;
        start_batch(5);
        for (int i = 0; i < 3; i++) engine_send(SUM_W'($urandom), 1);
        vectors++;
        if (fifo_count !== 3'd3) begin miscompares++; $display("FAIL flush pre count: got %0d, required 3", fifo_count); end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        vectors += 4;
        if (fifo_count !== '0) begin miscompares++; $display("FAIL flush count: got %0d, required 0", fifo_count); end
        if (busy !== 1'b0) begin miscompares++; $display("FAIL flush busy: got %b, required 0", busy); end
        if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL flush out_valid: got %b, required 0", bus.out_valid); end
        if (bus.mac_ready !== 1'b0) begin miscompares++; $display("FAIL flush mac_ready: got %b, required 0", bus.mac_ready); end
        bus.mac_valid = 1'b1;
        bus.mac_sum = SUM_W'($urandom);
        ready_force = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            vectors += 2;
            if (done !== 1'b0) begin miscompares++; $display("FAIL flush done cycle %0d: got %b, required 0", i, done); end
            if (fifo_count !== '0) begin miscompares++; $display("FAIL flush capture cycle %0d: got %0d, required 0", i, fifo_count); end
        end
        bus.mac_valid = 1'b0;
        vectors++;
        if (got_q.size() != base) begin miscompares++; $display("FAIL flush stream: got %0d items, required 0", got_q.size() - base); end
    endtask

    task automatic test_async_reset();
        ready_force = 1'b0;
        start_batch(3);
        for (int i = 0; i < 3; i++) engine_send(SUM_W'($urandom), 0);
        vectors += 2;
        if (busy !== 1'b1) begin miscompares++; $display("FAIL arst pre busy: got %b, required 1", busy); end
        if (fifo_count !== 3'd3) begin miscompares++; $display("FAIL arst pre count: got %0d, required 3", fifo_count); end
`ifdef COLLECTOR_CNT_EN
        vectors++;
        if (result_count !== 16'(sent_total)) begin miscompares++; $display("FAIL arst pre result_count: got %0d, required %0d", result_count, sent_total); end
`endif
        #2;
        nrst = 1'b0;
        #1;
        vectors += 6;
        if (bus.mac_ready !== 1'b0) begin miscompares++; $display("FAIL arst mac_ready: got %b, required 0", bus.mac_ready); end
        if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL arst out_valid: got %b, required 0", bus.out_valid); end
        if (bus.out_data !== '0) begin miscompares++; $display("FAIL arst out_data: got %h, required 0", bus.out_data); end
        if (fifo_count !== '0) begin miscompares++; $display("FAIL arst fifo_count: got %0d, required 0", fifo_count); end
        if (busy !== 1'b0) begin miscompares++; $display("FAIL arst busy: got %b, required 0", busy); end
        if (done !== 1'b0) begin miscompares++; $display("FAIL arst done: got %b, required 0", done); end
`ifdef COLLECTOR_CNT_EN
        vectors++;
        if (result_count !== 16'd0) begin miscompares++; $display("FAIL arst result_count: got %0d, required 0", result_count); end
`endif
        sent_total = 0;
        tick();
        nrst = 1'b1;
        tick();
    endtask

    initial begin
        bus.mac_valid = 1'b0;
        bus.mac_sum = '0;
        test_reset();
        test_single();
        test_zero_batch();
        test_backpressure();
        test_same_cycle();
        test_wrap_random();
        test_flush();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running at time limit, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
